// File: rtl/se_pkg.sv
// se_pkg -- shared constants for the rv32i immediate sign-extension unit.
//
// Contents:
//   INM_W        width of the instruction slice instr[31:7]
//   XLEN         datapath width
//   SRC_I/S/B/J  encodings of the immediate format selector
//
// Optional feature macro used by the files that import this package:
//   SE_UTYPE_EN  adds the U-format override input.
package se_pkg;

  localparam int INM_W = 25;
  localparam int XLEN  = 32;

  localparam logic [1:0] SRC_I = 2'b00;
  localparam logic [1:0] SRC_S = 2'b01;
  localparam logic [1:0] SRC_B = 2'b10;
  localparam logic [1:0] SRC_J = 2'b11;

endpackage : se_pkg

// File: rtl/se_fmt.sv
// se_fmt -- combinational immediate format decode and bit reassembly.
//
// Ports:
//   inm    in  [24:0]  instruction bits [31:7]; inm[k] = instr[k+7]
//   src    in  [1:0]   format select (SRC_I / SRC_S / SRC_B / SRC_J)
//   utype  in  1       U-format override (only when SE_UTYPE_EN is defined)
//   imm    out [31:0]  unregistered sign-extended immediate
//
// Macro: SE_UTYPE_EN -- when defined, utype=1 selects {instr[31:12], 12'b0}.
// All four src codes are legal, so the decode is full and never produces X.
module se_fmt
  import se_pkg::*;
(
  input  logic [INM_W-1:0] inm,
  input  logic [1:0]       src,
`ifdef SE_UTYPE_EN
  input  logic             utype,
`endif
  output logic [XLEN-1:0]  imm
);

  // instr[31] is the sign bit for every format.
  logic sign;
  assign sign = inm[24];

  always_comb begin
    imm = '0;
    case (src)
      SRC_I: imm = {{20{sign}}, inm[24:13]};
      SRC_S: imm = {{20{sign}}, inm[24:18], inm[4:0]};
      SRC_B: imm = {{19{sign}}, sign, inm[0], inm[23:18], inm[4:1], 1'b0};
      SRC_J: imm = {{11{sign}}, sign, inm[12:5], inm[13], inm[23:14], 1'b0};
      default: imm = '0;
    endcase
`ifdef SE_UTYPE_EN
    // LUI/AUIPC format overrides whatever src selects.
    if (utype) begin
      imm = {inm[24:5], 12'b0};
    end
`endif
  end

endmodule : se_fmt

// File: rtl/se.sv
// se -- registered immediate sign-extension unit for the rv32i datapath.
//
// Ports:
//   clk     in  1       clock, rising edge
//   reset   in  1       synchronous, active-high; clears inmExt
//   inm     in  [24:0]  instruction bits [31:7]
//   src     in  [1:0]   format select: 00=I, 01=S, 10=B, 11=J
//   utype   in  1       U-format override (only when SE_UTYPE_EN is defined)
//   inmExt  out [31:0]  sign-extended immediate, one cycle after sampling
//
// Macro: SE_UTYPE_EN -- adds the utype port.
// Handshake: none. The output register loads every cycle; there is no
// valid/ready or enable, and reset takes priority over the data path.
module se
  import se_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [INM_W-1:0] inm,
  input  logic [1:0]       src,
`ifdef SE_UTYPE_EN
  input  logic             utype,
`endif
  output logic [XLEN-1:0]  inmExt
);

  logic [XLEN-1:0] inmExt_d;
  logic [XLEN-1:0] inmExt_q;

  se_fmt u_fmt (
    .inm   (inm),
    .src   (src),
`ifdef SE_UTYPE_EN
    .utype (utype),
`endif
    .imm   (inmExt_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      inmExt_q <= '0;
    end else begin
      inmExt_q <= inmExt_d;
    end
  end

  assign inmExt = inmExt_q;

endmodule : se

// File: tb/tb_se.sv
// tb_se -- self-checking bench for se.
// Inputs are driven 2 time units after each rising edge; outputs are
// sampled on the falling edge. The reference model rebuilds the full
// instruction word and evaluates each immediate as a signed integer.
module tb_se;

  logic        clk;
  logic        reset;
  logic [24:0] inm;
  logic [1:0]  src;
  logic        ut_val;
  logic [31:0] inmExt;
`ifdef SE_UTYPE_EN
  logic        utype;
  assign utype = ut_val;
`endif

  int checks;
  int errors;
  logic [31:0] exp_q[$];

  se dut (
    .clk    (clk),
    .reset  (reset),
    .inm    (inm),
    .src    (src),
`ifdef SE_UTYPE_EN
    .utype  (utype),
`endif
    .inmExt (inmExt)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Gather the immediate field from the instruction word, then give it
  // its two's-complement value by subtracting 2^width when the top bit is set.
  function automatic logic [31:0] ref_imm(input logic [24:0] f_inm,
                                          input logic [1:0] f_src,
                                          input logic f_ut);
    logic [31:0] ins;
    longint      v;
    int          nbits;
    ins = {f_inm, 7'b0};
    if (f_ut) return {ins[31:12], 12'h000};
    case (f_src)
      2'd0: begin v = ins[31:20]; nbits = 12; end
      2'd1: begin v = {ins[31:25], ins[11:7]}; nbits = 12; end
      2'd2: begin v = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; nbits = 13; end
      default: begin v = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}; nbits = 21; end
    endcase
    if (ins[31]) v = v - (longint'(1) << nbits);
    return v[31:0];
  endfunction

  // Model: at each edge, push what the register must hold afterwards.
  always @(posedge clk) begin
    if (reset === 1'b1) exp_q.push_back(32'h0);
    else                exp_q.push_back(ref_imm(inm, src, ut_val));
  end

  // Compare process: every cycle after the first edge.
  always @(negedge clk) begin
    logic [31:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (inmExt !== e) begin
        errors++;
        $display("FAIL model t=%0t inmExt=%h expected=%h", $time, inmExt, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic [24:0] i, input logic [1:0] s,
                       input logic u);
    @(posedge clk);
    #2;
    reset  = r;
    inm    = i;
    src    = s;
    ut_val = u;
  endtask

  // Drive one vector, let one edge capture it, then check a literal value.
  task automatic step_check(input string name, input logic r, input logic [24:0] i,
                            input logic [1:0] s, input logic u, input logic [31:0] want);
    drive(r, i, s, u);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (inmExt !== want) begin
      errors++;
      $display("FAIL %s inmExt=%h expected=%h", name, inmExt, want);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset  = 1'b1;
    inm    = 25'h1FF_FFFF;
    src    = 2'b00;
    ut_val = 1'b0;
    checks = 0;
    errors = 0;

    // Reset held for two edges with all-ones input.
    @(posedge clk);
    step_check("reset", 1'b1, 25'h1FF_FFFF, 2'b00, 1'b0, 32'h0000_0000);

    // Directed vectors with hand-computed results.
    step_check("i_ones", 1'b0, 25'h1FF_FFFF, 2'b00, 1'b0, 32'hFFFF_FFFF);
    step_check("i_aaa",  1'b0, 25'b1010101010101111111111110, 2'b00, 1'b0, 32'hFFFF_FAAA);
    step_check("s_neg",  1'b0, 25'b1111111111111111100000000, 2'b01, 1'b0, 32'hFFFF_FFE0);
    step_check("b_sign", 1'b0, 25'b1000000000000000000000000, 2'b10, 1'b0, 32'hFFFF_F000);
    step_check("j_400",  1'b0, 25'b0100000000000000000000000, 2'b11, 1'b0, 32'h0000_0400);
    step_check("j_rst",  1'b1, 25'b0100000000000000000000000, 2'b11, 1'b0, 32'h0000_0000);
    step_check("j_rel",  1'b0, 25'b0100000000000000000000000, 2'b11, 1'b0, 32'h0000_0400);
    // Extra boundary points: positive I max, B low bit, J mid field.
    step_check("i_pos",  1'b0, 25'h0FF_FFFF, 2'b00, 1'b0, 32'h0000_07FF);
    step_check("b_bit11", 1'b0, 25'h000_0001, 2'b10, 1'b0, 32'h0000_0800);
    step_check("j_bit11", 1'b0, 25'h000_2000, 2'b11, 1'b0, 32'h0000_0800);
    step_check("s_low",  1'b0, 25'h000_001F, 2'b01, 1'b0, 32'h0000_001F);
`ifdef SE_UTYPE_EN
    step_check("u_ones", 1'b0, 25'h1FF_FFFF, 2'b10, 1'b1, 32'hFFFF_F000);
    step_check("u_low",  1'b0, 25'h000_0020, 2'b11, 1'b1, 32'h0000_1000);
`endif

    // Randomized stream with occasional mid-stream resets.
    for (int n = 0; n < 400; n++) begin
      logic u;
`ifdef SE_UTYPE_EN
      u = ($urandom_range(0, 3) == 0);
`else
      u = 1'b0;
`endif
      drive(($urandom_range(0, 15) == 0), 25'($urandom), 2'($urandom_range(0, 3)), u);
    end

    // Drain: let the last vector reach the output and be compared.
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_se

// File: doc/se.md
# se

Registered immediate sign-extension unit for the rv32i datapath. Takes instruction bits [31:7] and a 2-bit format selector from the control unit. Reassembles and sign-extends the I/S/B/J immediate to 32 bits. Feeds the ALU operand mux and the branch/jump target adder.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `inm`  in  25  instruction bits [31:7]; `inm[k]` = instr[k+7].
- `src`  in  2  immediate format select: 00 = I, 01 = S, 10 = B, 11 = J.
- `inmExt`  out  32  registered, sign-extended immediate.
- `utype`  in  1  present only with `SE_UTYPE_EN`; selects the U format.

## Operation
- The sign bit is always `inm[24]` (instr[31]). All upper fill bits copy it.
- I (00): imm[11:0] = `inm[24:13]`; bits [31:12] = sign.
- S (01): imm[11:5] = `inm[24:18]`, imm[4:0] = `inm[4:0]`; bits [31:12] = sign.
- B (10): imm[12] = `inm[24]`, imm[11] = `inm[0]`, imm[10:5] = `inm[23:18]`, imm[4:1] = `inm[4:1]`, imm[0] = 0; bits [31:13] = sign.
- J (11): imm[20] = `inm[24]`, imm[19:12] = `inm[12:5]`, imm[11] = `inm[13]`, imm[10:1] = `inm[23:14]`, imm[0] = 0; bits [31:21] = sign.
- Decode is full and purely combinational ahead of the register. No `src` value is illegal, and there is no X propagation from `src`.
- Data is pure bit selection. No arithmetic, no saturation, no truncation beyond the listed fields.

## Timing
- Latency is 1 cycle. `inmExt` at edge N+1 reflects `inm`/`src` sampled at edge N.
- Reset value: `inmExt` = 32'h0000_0000.
- `reset` high at a rising edge forces `inmExt` to 0 regardless of `inm`/`src`. Reset wins over any simultaneous input change.
- Reset asserted mid-stream discards the pending value. The first post-reset output follows the inputs sampled at the first edge with `reset` low.
- Inputs change freely between edges; only the value at the rising edge matters.
- There is no handshake and no enable: the register loads every cycle.

## Configuration
- `SE_UTYPE_EN` defined: adds the `utype` input.
  - `utype` = 1 overrides `src` and produces `{inm[24:5], 12'b0}` (LUI/AUIPC format).
  - `utype` = 0 gives the normal `src` decode.
- `SE_UTYPE_EN` undefined: no `utype` port; only the four `src` formats exist.
- Reset and latency behaviour are identical in both builds.

## Structure
- Shared package `se_pkg` holds:
  - `src` encodings `SRC_I` = 2'b00, `SRC_S` = 2'b01, `SRC_B` = 2'b10, `SRC_J` = 2'b11.
  - Width constants `INM_W` = 25 and `XLEN` = 32.
- One combinational sub-module, `se_fmt`, does format decode and bit reassembly.
  - Inputs: `inm`, `src`, and `utype` when enabled.
  - Output: unregistered 32-bit immediate.
- The top `se` holds only the output register and reset logic.

## Test plan
- Reset: hold `reset` = 1 for 2 edges with `inm` = all ones and `src` = 00 -> `inmExt` = 32'h0000_0000.
- I: `inm` = 25'h1FF_FFFF, `src` = 00 -> 32'hFFFF_FFFF one cycle later.
- I: then `inm` = 25'b1010101010101111111111110 -> 32'hFFFF_FAAA.
- S: `inm` = 25'b1111111111111111100000000, `src` = 01 -> 32'hFFFF_FFE0.
- B and J:
  - `inm` = 25'b1000000000000000000000000, `src` = 10 -> 32'hFFFF_F000.
  - Then `inm` = 25'b0100000000000000000000000, `src` = 11 -> 32'h0000_0400.
- Reset mid-stream and U-type:
  - Assert `reset` for one edge during the J vector -> 0, then 32'h0000_0400 again after release.
  - With `SE_UTYPE_EN`, `utype` = 1 and `inm` = 25'h1FF_FFFF -> 32'hFFFF_F000.
